// File: rtl/dmem_responder_if.sv
// MEM-stage data-memory request bus between the pipelined datapath (master)
// and the data-memory responder (slave).
interface dmem_responder_if #(
    parameter int DATA_W     = 32,
    parameter int DM_ADDRESS = 9
) ();
    logic                  MemRead;
    logic                  MemWrite;
    logic [DM_ADDRESS-1:0] addr;
    logic [DATA_W-1:0]     wr_data;
    logic [2:0]            func3;
    logic [DATA_W-1:0]     rd_data;

    modport master (
        output MemRead, MemWrite, addr, wr_data, func3,
        input  rd_data
    );

    modport slave (
        input  MemRead, MemWrite, addr, wr_data, func3,
        output rd_data
    );
endinterface

// File: rtl/dmem_responder.sv
// Byte-addressable data memory responder: RV32I lane steering and extension,
// access legality checks, sticky fault capture and saturating access counters.
module dmem_responder #(
    parameter int DATA_W     = 32,
    parameter int DM_ADDRESS = 9,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    dmem_responder_if.slave       bus,
    input  logic                  fault_clr,
    output logic                  fault,
    output logic [DM_ADDRESS-1:0] fault_addr,
    output logic [2:0]            fault_func3,
    output logic [CNT_W-1:0]      load_cnt,
    output logic [CNT_W-1:0]      store_cnt,
    input  logic [DM_ADDRESS-3:0] dbg_addr,
    output logic [DATA_W-1:0]     dbg_rdata
);
    localparam int DEPTH = 2 ** DM_ADDRESS;

    // Legal when size/sign code is valid for the direction and the lane is aligned.
    function automatic logic access_legal(input logic rd, input logic wr,
                                          input logic [2:0] f3, input logic [1:0] lane);
        logic ok;
        ok = 1'b0;
        if (rd && wr) begin
            ok = 1'b0;
        end else begin
            case (f3)
                3'b000:  ok = 1'b1;
                3'b001:  ok = ~lane[0];
                3'b010:  ok = (lane == 2'b00);
                3'b100:  ok = ~wr;
                3'b101:  ok = ~wr & ~lane[0];
                default: ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

    logic [7:0]            mem_r [DEPTH];
    logic                  fault_r;
    logic [DM_ADDRESS-1:0] fault_addr_r;
    logic [2:0]            fault_func3_r;
    logic [CNT_W-1:0]      load_cnt_r;
    logic [CNT_W-1:0]      store_cnt_r;

    logic [1:0]            lane_s;
    logic [DM_ADDRESS-3:0] word_idx_s;
    logic                  legal_s;
    logic                  illegal_s;
    logic                  load_ok_s;
    logic                  store_ok_s;
    logic [DATA_W-1:0]     ld_word_s;
    logic [7:0]            ld_byte_s;
    logic [15:0]           ld_half_s;
    logic [DATA_W-1:0]     rd_data_s;
    logic [3:0]            be_s;
    logic [DATA_W-1:0]     st_data_s;

    assign lane_s     = bus.addr[1:0];
    assign word_idx_s = bus.addr[DM_ADDRESS-1:2];
    assign legal_s    = access_legal(bus.MemRead, bus.MemWrite, bus.func3, lane_s);
    assign illegal_s  = (bus.MemRead | bus.MemWrite) & ~legal_s;
    assign load_ok_s  = bus.MemRead & legal_s;
    assign store_ok_s = bus.MemWrite & legal_s;

    assign ld_word_s = {mem_r[{word_idx_s, 2'b11}], mem_r[{word_idx_s, 2'b10}],
                        mem_r[{word_idx_s, 2'b01}], mem_r[{word_idx_s, 2'b00}]};
    assign dbg_rdata = {mem_r[{dbg_addr, 2'b11}], mem_r[{dbg_addr, 2'b10}],
                        mem_r[{dbg_addr, 2'b01}], mem_r[{dbg_addr, 2'b00}]};

    // Load path: pick the addressed lane(s) and extend; func3[2] selects zero extension.
    always_comb begin
        ld_byte_s = 8'h00;
        ld_half_s = 16'h0000;
        rd_data_s = {DATA_W{1'b0}};
        case (lane_s)
            2'b00:   ld_byte_s = ld_word_s[7:0];
            2'b01:   ld_byte_s = ld_word_s[15:8];
            2'b10:   ld_byte_s = ld_word_s[23:16];
            2'b11:   ld_byte_s = ld_word_s[31:24];
            default: ld_byte_s = 8'h00;
        endcase
        if (lane_s[1]) begin
            ld_half_s = ld_word_s[31:16];
        end else begin
            ld_half_s = ld_word_s[15:0];
        end
        if (load_ok_s) begin
            case (bus.func3[1:0])
                2'b00:   rd_data_s = {{24{~bus.func3[2] & ld_byte_s[7]}}, ld_byte_s};
                2'b01:   rd_data_s = {{16{~bus.func3[2] & ld_half_s[15]}}, ld_half_s};
                2'b10:   rd_data_s = ld_word_s;
                default: rd_data_s = {DATA_W{1'b0}};
            endcase
        end else begin
            rd_data_s = {DATA_W{1'b0}};
        end
    end

    assign bus.rd_data = rd_data_s;

    // Store path: byte enables per lane and store data replicated across lanes.
    always_comb begin
        be_s      = 4'b0000;
        st_data_s = bus.wr_data;
        case (bus.func3[1:0])
            2'b00: begin
                be_s      = 4'b0001 << lane_s;
                st_data_s = {4{bus.wr_data[7:0]}};
            end
            2'b01: begin
                be_s      = lane_s[1] ? 4'b1100 : 4'b0011;
                st_data_s = {2{bus.wr_data[15:0]}};
            end
            2'b10: begin
                be_s      = 4'b1111;
                st_data_s = bus.wr_data;
            end
            default: begin
                be_s      = 4'b0000;
                st_data_s = bus.wr_data;
            end
        endcase
    end

    // Memory array: cleared by reset, written lane by lane on legal stores.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 8'h00;
            end
        end else begin
            for (int j = 0; j < 4; j++) begin
                if (store_ok_s && be_s[j]) begin
                    mem_r[{word_idx_s, 2'(j)}] <= st_data_s[8*j +: 8];
                end
            end
        end
    end

    // Sticky fault capture; a new fault in the clearing cycle wins over the clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fault_r       <= 1'b0;
            fault_addr_r  <= {DM_ADDRESS{1'b0}};
            fault_func3_r <= 3'b000;
        end else if (illegal_s && (!fault_r || fault_clr)) begin
            fault_r       <= 1'b1;
            fault_addr_r  <= bus.addr;
            fault_func3_r <= bus.func3;
        end else if (fault_clr) begin
            fault_r       <= 1'b0;
            fault_addr_r  <= {DM_ADDRESS{1'b0}};
            fault_func3_r <= 3'b000;
        end
    end

    // Saturating counters of legal loads and stores.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            load_cnt_r  <= {CNT_W{1'b0}};
            store_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (load_ok_s && (load_cnt_r != {CNT_W{1'b1}})) begin
                load_cnt_r <= load_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (store_ok_s && (store_cnt_r != {CNT_W{1'b1}})) begin
                store_cnt_r <= store_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign fault       = fault_r;
    assign fault_addr  = fault_addr_r;
    assign fault_func3 = fault_func3_r;
    assign load_cnt    = load_cnt_r;
    assign store_cnt   = store_cnt_r;
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Responder for the MEM-stage data-memory request interface driven by the pipelined datapath (MemRead, MemWrite, 9-bit byte address, store data, funct3). Holds a 512-byte flop-based byte-addressable memory. Performs RV32I byte-lane steering and sign/zero extension, and detects misaligned or illegal accesses. Keeps sticky fault capture and saturating access counters for testbench and debug visibility.

Parameters:
DATA_W, 32, data word width (fixed at 32; the byte-lane logic assumes 4 lanes)
DM_ADDRESS, 9, byte address width; depth = 2**DM_ADDRESS bytes
CNT_W, 16, width of load/store counters

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
MemRead  in  1  load request, MEM stage
MemWrite  in  1  store request, MEM stage
addr  in  DM_ADDRESS  byte address
wr_data  in  DATA_W  store data, right-aligned
func3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
rd_data  out  DATA_W  load data, extended, combinational
fault_clr  in  1  clears sticky fault state
fault  out  1  sticky fault flag
fault_addr  out  DM_ADDRESS  address of first faulting access
fault_func3  out  3  func3 of first faulting access
load_cnt  out  CNT_W  successful loads, saturating
store_cnt  out  CNT_W  successful stores, saturating
dbg_addr  in  DM_ADDRESS-2  word index for debug readback
dbg_rdata  out  DATA_W  raw word at dbg_addr, combinational, little-endian

Behaviour:
- Reset (reset=0, async): all memory bytes=0, fault=0, fault_addr=0, fault_func3=0, load_cnt=0, store_cnt=0. rd_data=0 while no valid load is present. Reset asserted mid-store: the store is lost and the array stays cleared.
- Memory is little-endian. Word index = addr[8:2]; byte lane = addr[1:0].
- Access legality:
  - Byte access: any address is legal.
  - Half access: requires addr[0]=0.
  - Word access: requires addr[1:0]=00.
  - func3 011/110/111 is illegal for both loads and stores.
  - func3 100/101 is illegal for stores.
  - MemRead=1 together with MemWrite=1 is illegal.
- Loads: zero latency, combinational from the current array contents, so the datapath samples rd_data at the same edge.
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - Illegal load: rd_data=0.
  - MemRead=0: rd_data=0.
- Stores: committed at the rising clk edge while MemWrite=1 and the access is legal.
  - SB writes wr_data[7:0] to lane addr[1:0].
  - SH writes wr_data[15:0] to lanes addr[1:0] and addr[1:0]+1.
  - SW writes all four lanes.
  - Unwritten lanes are unchanged.
  - Illegal store writes nothing.
- Ordering: a load in cycle N+1 observes a store committed at the end of cycle N. There is no same-cycle bypass, because a store and a load never share a cycle.
- Fault capture, on the clock edge:
  - Any illegal access while fault=0 sets fault=1 and latches addr and func3.
  - Further faults do not overwrite the captured values.
  - fault_clr=1 clears all three outputs.
  - fault_clr=1 in the same cycle as a new illegal access: the new fault is captured (fault=1 with new addr/func3).
- Counters:
  - load_cnt increments on each cycle with a legal load.
  - store_cnt increments on each legal store.
  - Both saturate at all-ones (no wrap).
  - Illegal accesses do not count.
- Debug port: dbg_rdata = {byte[4k+3], byte[4k+2], byte[4k+1], byte[4k]} with k=dbg_addr. It has no side effects and does not affect the counters.
- Address wrap is not possible: the address width exactly covers the array.

Test Plan:
- Reset, then SW addr=0x010 data=0xDEADBEEF; next cycle LW 0x010 -> rd_data=0xDEADBEEF, dbg_addr=4 -> dbg_rdata=0xDEADBEEF, store_cnt=1, load_cnt=1.
- After the above:
  - SB addr=0x011 data=0x000000AA -> LW 0x010 = 0xDEADAAEF.
  - LB 0x011 -> 0xFFFFFFAA.
  - LBU 0x011 -> 0x000000AA.
  - LH 0x012 -> 0xFFFFDEAD.
  - LHU 0x012 -> 0x0000DEAD.
- SH addr=0x021 data=0x1234 -> no write (dbg word 8 stays 0), fault=1, fault_addr=0x021, fault_func3=001, store_cnt unchanged. Then LW 0x022 -> rd_data=0, fault_addr stays 0x021. Then fault_clr=1 with a simultaneous LW 0x003 -> fault=1, fault_addr=0x003, fault_func3=010.
- MemRead=1 and MemWrite=1 at addr 0x040 -> no write, rd_data=0, fault=1. Store with func3=100 -> no write, fault captured.
- Drive 0x10005 legal loads -> load_cnt=0xFFFF and holds there.
- Issue SW 0x080 data=0x55AA55AA and assert reset low mid-cycle before the edge -> all outputs 0 immediately. After release, dbg_addr=0x20 -> dbg_rdata=0.
